syscall_issue_queue: RTL
========================

// Module: syscall_issue_queue
// PURPOSE
//   Sits directly upstream of the syscall display/exit unit. Captures syscall requests
//   (code plus four argument words) from register read, buffers them in order, and
//   replays them to the syscall unit's instr_ID/rs/rt1..rt4 inputs one at a time.
//   Each issue is followed by a blanking cycle, so back-to-back identical syscalls each
//   retrigger the downstream combinational display.
// PARAMETERS
//   DEPTH   4    queue entries (power of two, >=2)
//   PTR_W   2    log2(DEPTH)
//   SYS_ID  26   decoded instruction ID that denotes syscall
// PORTS
//   clk           in   1       system clock, rising edge
//   reset         in   1       asynchronous, active-low reset
//   req_valid     in   1       request offered this cycle
//   req_ready     out  1       queue can accept (combinational)
//   req_instr_id  in   32      decoded instruction ID of offered instruction
//   req_code      in   32      syscall code (rs value)
//   req_arg1..4   in   32 ea   argument words (rt1..rt4 values)
//   instr_ID      out  32      to syscall unit: SYS_ID while issuing, else 0
//   rs            out  32      to syscall unit: code of issuing entry
//   rt1..rt4      out  32 ea   to syscall unit: arguments of issuing entry
//   busy          out  1       queue non-empty or FSM not IDLE (pipeline stall hint)
//   exit_pending  out  1       exit request accepted; no further requests accepted
//   drop_count    out  8       count of requests dropped for illegal code (saturating)
// BEHAVIOUR
//   Reset (reset=0, async): all outputs 0, queue empty, FSM=IDLE, pointers 0,
//     exit latch clear. req_ready becomes 1 once reset deasserts.
//   req_ready = (count<DEPTH) && !exit_pending.
//   Accept: req_valid && req_ready at rising edge.
//     req_instr_id!=SYS_ID: consumed, no enqueue, no side effect.
//     req_code 0 or >8: consumed, not enqueued, drop_count+1 (saturates at 255).
//     req_code 3 (nop): consumed, not enqueued, no issue.
//     req_code 1,2,4..8: enqueued in arrival order. Code 2 also sets exit_pending
//       on the same edge.
//   FSM IDLE -> ISSUE when queue non-empty (one cycle after enqueue at the earliest).
//     ISSUE (1 cycle): instr_ID=SYS_ID, rs/rt* = head entry, head popped at end.
//       If the entry is code 2, go to HALT; otherwise go to GAP.
//     GAP (1 cycle): instr_ID=0, rs/rt* hold last values. -> ISSUE if non-empty, else IDLE.
//     HALT: instr_ID=SYS_ID, rs=2 held indefinitely; leaves only on reset.
//   Issue rate: at most one syscall every 2 cycles. Latency from accept into an empty
//     idle queue to ISSUE is 1 cycle.
//   Outputs rs/rt*/instr_ID are registered; no combinational path from req_* to them.
//   Simultaneous enqueue and pop in the same cycle is legal; count is unchanged.
//   Full: req_ready=0; an offered request is held by the sender, not lost.
//   Pointers wrap modulo DEPTH; count ranges 0..DEPTH (PTR_W+1 bits).
//   Once exit_pending=1, entries already queued ahead of the exit still issue in order
//     before HALT.
//   Reset mid-operation discards all queued entries and any in-flight issue; instr_ID
//     drops to 0 asynchronously.
//   busy = (count!=0) || (state!=IDLE).
// TESTING
//   1. reset=0 for 3 cycles, then release -> all outputs 0, req_ready=1, busy=0.
//   2. One request code=1, arg1=32'hFFFFFFFB -> next cycle instr_ID=26, rs=1,
//        rt1=FFFFFFFB for 1 cycle, then instr_ID=0 for 1 cycle, then IDLE.
//   3. Two identical code=8, arg1=7 back-to-back -> two ISSUE pulses with instr_ID
//        26,0,26,0 over cycles t+1..t+4.
//   4. Offer 6 code=4 requests with req_valid held high -> req_ready drops after 4
//        in flight; all 6 issue in order (arg1 = 0..5); none lost.
//   5. Codes 0, 9, 3 and one non-syscall ID=5 -> none issued; drop_count=2.
//   6. Queue code=7, then code=2, then code=1 -> code 1 refused (req_ready=0);
//        code 7 issues, then HALT with rs=2 held; a reset during HALT returns to IDLE.

Source files
------------

// File: rtl/syscall_issue_queue.sv
// Syscall issue queue: in-order buffer between register read and the syscall unit.
// Latency: accept into an empty idle queue -> ISSUE on the next clock; each issue is followed by a blanking cycle.
// Backpressure: req_ready drops when the queue is full, after an exit is accepted, or while in reset; the sender holds its request.

// Generic FIFO with an occupancy count.
// Latency: a pushed entry is visible on rdat the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; callers gate with full/empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdat,
  input  logic             pop,
  output logic [WIDTH-1:0] rdat,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdat    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdat;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks simultaneous push/pop as no change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// Syscall issue queue top: filters, buffers and replays syscall requests.
// Latency: one cycle from accept into an empty idle queue to ISSUE; at most one issue every two cycles.
// Backpressure: req_ready = in reset ? 0 : (not full && no exit pending); refused requests stay with the sender.
module syscall_issue_queue #(
  parameter int          DEPTH  = 4,
  parameter int          PTR_W  = 2,
  parameter logic [31:0] SYS_ID = 32'd26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_instr_id,
  input  logic [31:0] req_code,
  input  logic [31:0] req_arg1,
  input  logic [31:0] req_arg2,
  input  logic [31:0] req_arg3,
  input  logic [31:0] req_arg4,
  output logic [31:0] instr_ID,
  output logic [31:0] rs,
  output logic [31:0] rt1,
  output logic [31:0] rt2,
  output logic [31:0] rt3,
  output logic [31:0] rt4,
  output logic        busy,
  output logic        exit_pending,
  output logic [7:0]  drop_count
);

  typedef struct packed {
    logic [31:0] code;
    logic [31:0] arg1;
    logic [31:0] arg2;
    logic [31:0] arg3;
    logic [31:0] arg4;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t          state;
  entry_t          push_entry;
  entry_t          head;
  logic [PTR_W:0]  count;
  logic            full;
  logic            empty;
  logic            accept;
  logic            is_sys;
  logic            code_bad;
  logic            code_keep;
  logic            push;
  logic            drop;
  logic            pop;

  // Codes 0 and above 8 are illegal; code 3 is a nop that is swallowed silently.
  assign accept     = req_valid && req_ready;
  assign is_sys     = (req_instr_id == SYS_ID);
  assign code_bad   = (req_code == 32'd0) || (req_code > 32'd8);
  assign code_keep  = !code_bad && (req_code != 32'd3);
  assign push       = accept && is_sys && code_keep;
  assign drop       = accept && is_sys && code_bad;
  assign pop        = (state == ISSUE);
  assign push_entry = '{req_code, req_arg1, req_arg2, req_arg3, req_arg4};

  // Ready is forced low while reset is held so every output reads 0 in reset.
  assign req_ready = reset && !full && !exit_pending;
  assign busy      = (count != '0) || (state != IDLE);

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdat  (push_entry),
    .pop   (pop),
    .rdat  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Exit latch: set on the edge that enqueues a code-2 request, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exit_pending <= 1'b0;
    end else if (push && (req_code == 32'd2)) begin
      exit_pending <= 1'b1;
    end
  end

  // Saturating count of requests rejected for an illegal code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= 8'd0;
    end else if (drop && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  // Issue FSM with registered outputs; the head entry is presented in ISSUE and popped as ISSUE ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      instr_ID <= 32'd0;
      rs       <= 32'd0;
      rt1      <= 32'd0;
      rt2      <= 32'd0;
      rt3      <= 32'd0;
      rt4      <= 32'd0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (!empty) begin
            state    <= ISSUE;
            instr_ID <= SYS_ID;
            rs       <= head.code;
            rt1      <= head.arg1;
            rt2      <= head.arg2;
            rt3      <= head.arg3;
            rt4      <= head.arg4;
          end else begin
            state    <= IDLE;
            instr_ID <= 32'd0;
          end
        end
        ISSUE: begin
          // An exit keeps instr_ID asserted and rs=2 forever; anything else blanks for one cycle.
          if (rs == 32'd2) begin
            state <= HALT;
          end else begin
            state    <= GAP;
            instr_ID <= 32'd0;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state    <= IDLE;
          instr_ID <= 32'd0;
        end
      endcase
    end
  end

endmodule
